// File: rtl/mic1_alu_shift_unit_if.sv
// mic1_alu_shift_unit_if: operand, control and result bundle for the Mic-1
// execution stage. The master side (microsequencer/datapath control) drives
// operands and controls; the slave side (the ALU/shifter) returns combinational
// and registered results.
// Optional feature macro: MIC1_ALU_CARRY_EN adds cout / cout_q.
interface mic1_alu_shift_unit_if #(
  parameter int WIDTH = 32
);
  logic             en;
  logic [5:0]       alu_ctrl;
  logic [1:0]       shift_ctrl;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] alu_out;
  logic             n;
  logic             z;
  logic [WIDTH-1:0] c;
  logic [WIDTH-1:0] c_q;
  logic             n_q;
  logic             z_q;
`ifdef MIC1_ALU_CARRY_EN
  logic             cout;
  logic             cout_q;
`endif

`ifdef MIC1_ALU_CARRY_EN
  modport master (
    output en, alu_ctrl, shift_ctrl, a, b,
    input  alu_out, n, z, c, c_q, n_q, z_q, cout, cout_q
  );
  modport slave (
    input  en, alu_ctrl, shift_ctrl, a, b,
    output alu_out, n, z, c, c_q, n_q, z_q, cout, cout_q
  );
`else
  modport master (
    output en, alu_ctrl, shift_ctrl, a, b,
    input  alu_out, n, z, c, c_q, n_q, z_q
  );
  modport slave (
    input  en, alu_ctrl, shift_ctrl, a, b,
    output alu_out, n, z, c, c_q, n_q, z_q
  );
`endif
endinterface

// File: rtl/mic1_alu_shift_unit.sv
// mic1_alu_shift_unit: Mic-1 execution stage. A 6-control-bit ALU
// {F0,F1,ENA,ENB,INVA,INC} followed by the 2-bit shifter {SLL8,SRA1} that
// drives the C bus. alu_out, n, z and c are combinational for same-cycle use
// (e.g. MPC next-address logic); c_q, n_q, z_q are the captured copies.
// WIDTH must be at least 16 so the 8-bit left shift leaves a meaningful field.
// Optional feature macro: MIC1_ALU_CARRY_EN exposes the adder carry as
// cout / cout_q; without it the carry is discarded.
module mic1_alu_shift_unit #(
  parameter int WIDTH = 32
) (
  input  logic                        clk,
  input  logic                        resetn,
  mic1_alu_shift_unit_if.slave        bus
);

  // Control field decode
  logic [1:0]       f_s;
  logic             ena_s;
  logic             enb_s;
  logic             inva_s;
  logic             inc_s;
  logic             sll8_s;
  logic             sra1_s;

  // Datapath intermediates
  logic [WIDTH-1:0] a_g_s;
  logic [WIDTH-1:0] b_g_s;
  logic [WIDTH-1:0] a_e_s;
  logic [WIDTH-1:0] alu_s;
  logic [WIDTH-1:0] shl_s;
  logic [WIDTH-1:0] c_s;
  logic             n_s;
  logic             z_s;

  // Output registers
  logic [WIDTH-1:0] c_r;
  logic             n_r;
  logic             z_r;

`ifdef MIC1_ALU_CARRY_EN
  logic [WIDTH:0]   sum_s;
  logic             cout_s;
  logic             cout_r;
`else
  logic [WIDTH-1:0] sum_s;
`endif

  assign f_s    = bus.alu_ctrl[5:4];
  assign ena_s  = bus.alu_ctrl[3];
  assign enb_s  = bus.alu_ctrl[2];
  assign inva_s = bus.alu_ctrl[1];
  assign inc_s  = bus.alu_ctrl[0];
  assign sll8_s = bus.shift_ctrl[1];
  assign sra1_s = bus.shift_ctrl[0];

  // Operand gating, then inversion of the gated A (disabled+inverted A is all ones)
  always_comb begin
    if (ena_s) begin
      a_g_s = bus.a;
    end else begin
      a_g_s = {WIDTH{1'b0}};
    end
    if (enb_s) begin
      b_g_s = bus.b;
    end else begin
      b_g_s = {WIDTH{1'b0}};
    end
    if (inva_s) begin
      a_e_s = ~a_g_s;
    end else begin
      a_e_s = a_g_s;
    end
  end

`ifdef MIC1_ALU_CARRY_EN
  // Adder with carry kept one bit above the datapath
  assign sum_s = {1'b0, a_e_s} + {1'b0, b_g_s} + {{WIDTH{1'b0}}, inc_s};
`else
  // Adder modulo 2^WIDTH; carry is dropped
  assign sum_s = a_e_s + b_g_s + {{(WIDTH-1){1'b0}}, inc_s};
`endif

  // Function select; INC only reaches the result through the adder
  always_comb begin
    alu_s = {WIDTH{1'b0}};
`ifdef MIC1_ALU_CARRY_EN
    cout_s = 1'b0;
`endif
    case (f_s)
      2'b00: alu_s = a_e_s & b_g_s;
      2'b01: alu_s = a_e_s | b_g_s;
      2'b10: alu_s = ~b_g_s;
      default: begin
`ifdef MIC1_ALU_CARRY_EN
        alu_s  = sum_s[WIDTH-1:0];
        cout_s = sum_s[WIDTH];
`else
        alu_s  = sum_s;
`endif
      end
    endcase
  end

  // Flags come from the ALU result, ahead of the shifter
  assign n_s = alu_s[WIDTH-1];
  assign z_s = (alu_s == {WIDTH{1'b0}});

  // Shifter: optional SLL8 first, then optional SRA1 on that result
  always_comb begin
    if (sll8_s) begin
      shl_s = {alu_s[WIDTH-9:0], 8'h00};
    end else begin
      shl_s = alu_s;
    end
    if (sra1_s) begin
      c_s = {shl_s[WIDTH-1], shl_s[WIDTH-1:1]};
    end else begin
      c_s = shl_s;
    end
  end

  // Capture C bus and flags when enabled; async clear on resetn low
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      c_r <= {WIDTH{1'b0}};
      n_r <= 1'b0;
      z_r <= 1'b0;
`ifdef MIC1_ALU_CARRY_EN
      cout_r <= 1'b0;
`endif
    end else if (bus.en) begin
      c_r <= c_s;
      n_r <= n_s;
      z_r <= z_s;
`ifdef MIC1_ALU_CARRY_EN
      cout_r <= cout_s;
`endif
    end
  end

  assign bus.alu_out = alu_s;
  assign bus.n       = n_s;
  assign bus.z       = z_s;
  assign bus.c       = c_s;
  assign bus.c_q     = c_r;
  assign bus.n_q     = n_r;
  assign bus.z_q     = z_r;
`ifdef MIC1_ALU_CARRY_EN
  assign bus.cout    = cout_s;
  assign bus.cout_q  = cout_r;
`endif

endmodule

// File: tb/tb_mic1_alu_shift_unit.sv
// tb_mic1_alu_shift_unit: directed table of ALU/shifter vectors with
// hand-computed results, plus hand-written register/reset sequences.
// Optional feature macro: MIC1_ALU_CARRY_EN enables the carry checks.
module tb_mic1_alu_shift_unit;

  localparam int W = 32;

  logic clk;
  logic resetn;
  int   checks;
  int   failures;

  mic1_alu_shift_unit_if #(.WIDTH(W)) bus ();

  mic1_alu_shift_unit #(.WIDTH(W)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [5:0]   ctrl;
    logic [1:0]   sh;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] exp_alu;
    logic         exp_n;
    logic         exp_z;
    logic [W-1:0] exp_c;
  } vec_t;

  localparam int NV = 22;
  vec_t vecs [NV];

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [5:0] ctrl, input logic [1:0] sh,
                       input logic [W-1:0] a, input logic [W-1:0] b, input logic en);
    bus.alu_ctrl   = ctrl;
    bus.shift_ctrl = sh;
    bus.a          = a;
    bus.b          = b;
    bus.en         = en;
  endtask

  task automatic check_regs(input string tag, input logic [W-1:0] c, input logic n, input logic z);
    check({tag, "_c_q"}, bus.c_q, c);
    check({tag, "_n_q"}, {31'd0, bus.n_q}, {31'd0, n});
    check({tag, "_z_q"}, {31'd0, bus.z_q}, {31'd0, z});
  endtask

  initial begin
    checks   = 0;
    failures = 0;

    //            ctrl       sh     a              b              alu            n     z     c
    vecs[0]  = '{6'b111100, 2'b00, 32'h0000_0005, 32'h0000_0003, 32'h0000_0008, 1'b0, 1'b0, 32'h0000_0008};
    vecs[1]  = '{6'b111111, 2'b00, 32'h0000_0005, 32'h0000_0003, 32'hFFFF_FFFE, 1'b1, 1'b0, 32'hFFFF_FFFE};
    vecs[2]  = '{6'b110110, 2'b00, 32'h0000_0005, 32'h0000_0003, 32'h0000_0002, 1'b0, 1'b0, 32'h0000_0002};
    vecs[3]  = '{6'b111011, 2'b00, 32'h0000_0005, 32'h0000_0003, 32'hFFFF_FFFB, 1'b1, 1'b0, 32'hFFFF_FFFB};
    vecs[4]  = '{6'b111101, 2'b00, 32'h0000_0005, 32'h0000_0003, 32'h0000_0009, 1'b0, 1'b0, 32'h0000_0009};
    vecs[5]  = '{6'b111001, 2'b00, 32'h0000_0005, 32'h0000_0003, 32'h0000_0006, 1'b0, 1'b0, 32'h0000_0006};
    vecs[6]  = '{6'b110101, 2'b00, 32'h0000_0005, 32'h0000_0003, 32'h0000_0004, 1'b0, 1'b0, 32'h0000_0004};
    vecs[7]  = '{6'b010100, 2'b00, 32'h0000_0005, 32'h0000_0003, 32'h0000_0003, 1'b0, 1'b0, 32'h0000_0003};
    vecs[8]  = '{6'b011010, 2'b00, 32'h0000_0005, 32'h0000_0003, 32'hFFFF_FFFA, 1'b1, 1'b0, 32'hFFFF_FFFA};
    vecs[9]  = '{6'b101100, 2'b00, 32'h0000_0005, 32'h0000_0003, 32'hFFFF_FFFC, 1'b1, 1'b0, 32'hFFFF_FFFC};
    vecs[10] = '{6'b001101, 2'b00, 32'h0000_0005, 32'h0000_0003, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0001};
    vecs[11] = '{6'b010000, 2'b00, 32'h1234_5678, 32'h9ABC_DEF0, 32'h0000_0000, 1'b0, 1'b1, 32'h0000_0000};
    vecs[12] = '{6'b110001, 2'b00, 32'h1234_5678, 32'h9ABC_DEF0, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0001};
    vecs[13] = '{6'b110010, 2'b00, 32'h1234_5678, 32'h9ABC_DEF0, 32'hFFFF_FFFF, 1'b1, 1'b0, 32'hFFFF_FFFF};
    vecs[14] = '{6'b001100, 2'b00, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'h00F0_00F0, 1'b0, 1'b0, 32'h00F0_00F0};
    vecs[15] = '{6'b011100, 2'b00, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'hFFF0_FFF0, 1'b1, 1'b0, 32'hFFF0_FFF0};
    vecs[16] = '{6'b011000, 2'b10, 32'h8000_00FF, 32'h0000_0000, 32'h8000_00FF, 1'b1, 1'b0, 32'h0000_FF00};
    vecs[17] = '{6'b011000, 2'b01, 32'h8000_00FF, 32'h0000_0000, 32'h8000_00FF, 1'b1, 1'b0, 32'hC000_007F};
    vecs[18] = '{6'b011000, 2'b11, 32'h8000_00FF, 32'h0000_0000, 32'h8000_00FF, 1'b1, 1'b0, 32'h0000_7F80};
    vecs[19] = '{6'b011000, 2'b00, 32'h8000_00FF, 32'h0000_0000, 32'h8000_00FF, 1'b1, 1'b0, 32'h8000_00FF};
    vecs[20] = '{6'b011000, 2'b10, 32'h0000_0100, 32'h0000_0000, 32'h0000_0100, 1'b0, 1'b0, 32'h0001_0000};
    vecs[21] = '{6'b010000, 2'b01, 32'h8000_0001, 32'h0000_0000, 32'h0000_0000, 1'b0, 1'b1, 32'h0000_0000};

    // Reset held with en=1 across clock edges: registers must stay zero
    resetn = 1'b0;
    drive(6'b110010, 2'b00, 32'h0, 32'h0, 1'b1);
    repeat (3) @(posedge clk);
    #1;
    check_regs("reset_hold", 32'h0, 1'b0, 1'b0);

    // Combinational table (en=0 so registers stay put meanwhile)
    for (int i = 0; i < NV; i++) begin
      drive(vecs[i].ctrl, vecs[i].sh, vecs[i].a, vecs[i].b, 1'b0);
      #1;
      check($sformatf("v%0d_alu", i), bus.alu_out, vecs[i].exp_alu);
      check($sformatf("v%0d_n", i), {31'd0, bus.n}, {31'd0, vecs[i].exp_n});
      check($sformatf("v%0d_z", i), {31'd0, bus.z}, {31'd0, vecs[i].exp_z});
      check($sformatf("v%0d_c", i), bus.c, vecs[i].exp_c);
    end

    // Release reset away from the edge; first capture on the next rising edge
    @(negedge clk);
    resetn = 1'b1;
    drive(6'b110010, 2'b00, 32'h5, 32'h3, 1'b1);
    @(posedge clk);
    #1;
    check_regs("cap_m1", 32'hFFFF_FFFF, 1'b1, 1'b0);

    // en=0 with new inputs: hold
    @(negedge clk);
    drive(6'b010000, 2'b01, 32'h5, 32'h3, 1'b0);
    @(posedge clk);
    #1;
    check_regs("hold", 32'hFFFF_FFFF, 1'b1, 1'b0);

    // en=1 with zero result: capture z_q=1
    @(negedge clk);
    bus.en = 1'b1;
    @(posedge clk);
    #1;
    check_regs("cap_zero", 32'h0, 1'b0, 1'b1);

    // Capture a shifted value, then assert reset between edges
    @(negedge clk);
    drive(6'b011000, 2'b11, 32'h8000_00FF, 32'h0, 1'b1);
    @(posedge clk);
    #1;
    check_regs("cap_shift", 32'h0000_7F80, 1'b1, 1'b0);
    #2;
    resetn = 1'b0;
    #1;
    check_regs("async_rst", 32'h0, 1'b0, 1'b0);
    check("rst_comb_c", bus.c, 32'h0000_7F80);

    // First edge after release captures
    @(negedge clk);
    resetn = 1'b1;
    drive(6'b111111, 2'b00, 32'h5, 32'h3, 1'b1);
    @(posedge clk);
    #1;
    check_regs("post_rst", 32'hFFFF_FFFE, 1'b1, 1'b0);

`ifdef MIC1_ALU_CARRY_EN
    @(negedge clk);
    drive(6'b111100, 2'b00, 32'hFFFF_FFFF, 32'h1, 1'b1);
    #1;
    check("cy_alu", bus.alu_out, 32'h0);
    check("cy_cout", {31'd0, bus.cout}, 32'd1);
    check("cy_z", {31'd0, bus.z}, 32'd1);
    @(posedge clk);
    #1;
    check("cy_cout_q", {31'd0, bus.cout_q}, 32'd1);
    @(negedge clk);
    drive(6'b011100, 2'b00, 32'hFFFF_FFFF, 32'h1, 1'b0);
    #1;
    check("cy_or_cout", {31'd0, bus.cout}, 32'd0);
    @(posedge clk);
    #1;
    check("cy_hold_q", {31'd0, bus.cout_q}, 32'd1);
    #2;
    resetn = 1'b0;
    #1;
    check("cy_rst_q", {31'd0, bus.cout_q}, 32'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
